// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - command/status bus from uart_cmd_rx to the voltage-control / I2C stage
//
// Signals:
//   cmd_valid_o  one-cycle strobe, frame accepted (checksum good)
//   cmd_o        opcode of the last accepted frame
//   data_o       argument of the last accepted frame, {hi, lo}
//   chk_err_o    one-cycle strobe, frame checksum mismatch
//   frm_err_o    one-cycle strobe, stop bit sampled low
//   busy_o       parser is inside a frame (outside the header-hunt state)
// master: the receiver drives the bus; slave: the downstream consumer.

interface uart_cmd_rx_if;
    logic        cmd_valid_o;
    logic [7:0]  cmd_o;
    logic [15:0] data_o;
    logic        chk_err_o;
    logic        frm_err_o;
    logic        busy_o;

    modport master (
        output cmd_valid_o,
        output cmd_o,
        output data_o,
        output chk_err_o,
        output frm_err_o,
        output busy_o
    );

    modport slave (
        input cmd_valid_o,
        input cmd_o,
        input data_o,
        input chk_err_o,
        input frm_err_o,
        input busy_o
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with 5-byte command-frame decoder
//
// Parameters:
//   CLK_DIV  clocks per bit (>= 4)
//   TIMEOUT  clocks of inter-byte silence that abort a partial frame
// Ports:
//   clk      system clock
//   rst      synchronous reset, active high
//   rxd_i    asynchronous serial input, idle high
//   cmd_if   command/status bus (master side)
// Frame format: A5, cmd, hi, lo, cmd^hi^lo.

module uart_cmd_rx #(
    parameter int CLK_DIV = 434,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd_i,
    uart_cmd_rx_if.master cmd_if
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_CMD, P_DHI, P_DLO, P_CHK} p_state_t;

    // Two-flop synchroniser, idle-high reset so no false start after reset.
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd_i;
            rxs     <= rx_meta;
        end
    end

    // ---------------- receive FSM ----------------
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    byte_q;
    logic          byte_stb;
    logic          frm_err;
    logic          sample_data;
    logic          stop_sample;

    always_comb begin
        rx_next     = rx_state;
        sample_data = 1'b0;
        stop_sample = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (!rxs) rx_next = R_START;
            end
            R_START: begin
                // Mid-start check rejects glitches shorter than half a bit.
                if (bit_cnt == HALF_LAST) rx_next = rxs ? R_IDLE : R_DATA;
            end
            R_DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    sample_data = 1'b1;
                    if (bit_idx == 3'd7) rx_next = R_STOP;
                end
            end
            R_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (bit_cnt == BIT_LAST) begin
                    stop_sample = 1'b1;
                    rx_next     = R_IDLE;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            byte_q   <= 8'h00;
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            // Counter restarts on every state change and wraps each data bit.
            if (rx_state == R_IDLE || rx_next != rx_state || bit_cnt == BIT_LAST)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CW'(1);
            if (rx_state == R_IDLE)
                bit_idx <= 3'd0;
            else if (sample_data)
                bit_idx <= bit_idx + 3'd1;
            if (sample_data)
                shreg <= {rxs, shreg[7:1]};
            if (stop_sample)
                byte_q <= shreg;
            byte_stb <= stop_sample & rxs;
            frm_err  <= stop_sample & ~rxs;
        end
    end

    // ---------------- frame parser ----------------
    p_state_t      p_state;
    p_state_t      p_next;
    logic [7:0]    cmd_s;
    logic [7:0]    hi_s;
    logic [7:0]    lo_s;
    logic [TW-1:0] t_cnt;
    logic          frame_ok;
    logic          frame_bad;
    logic          cmd_valid_q;
    logic          chk_err_q;
    logic [7:0]    cmd_q;
    logic [15:0]   data_q;

    always_comb begin
        p_next    = p_state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (byte_stb) begin
            // A consumed byte takes priority over a coincident timeout.
            case (p_state)
                P_HDR:   if (byte_q == HDR_BYTE) p_next = P_CMD;
                P_CMD:   p_next = P_DHI;
                P_DHI:   p_next = P_DLO;
                P_DLO:   p_next = P_CHK;
                P_CHK: begin
                    p_next = P_HDR;
                    if (byte_q == (cmd_s ^ hi_s ^ lo_s)) frame_ok  = 1'b1;
                    else                                 frame_bad = 1'b1;
                end
                default: p_next = P_HDR;
            endcase
        end else if (p_state != P_HDR && (frm_err || t_cnt == TO_LAST)) begin
            p_next = P_HDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state     <= P_HDR;
            cmd_s       <= 8'h00;
            hi_s        <= 8'h00;
            lo_s        <= 8'h00;
            t_cnt       <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            cmd_q       <= 8'h00;
            data_q      <= 16'h0000;
        end else begin
            p_state <= p_next;
            if (byte_stb) begin
                case (p_state)
                    P_CMD:   cmd_s <= byte_q;
                    P_DHI:   hi_s  <= byte_q;
                    P_DLO:   lo_s  <= byte_q;
                    default: ;
                endcase
            end
            if (p_state == P_HDR || byte_stb)
                t_cnt <= '0;
            else
                t_cnt <= t_cnt + TW'(1);
            cmd_valid_q <= frame_ok;
            chk_err_q   <= frame_bad;
            if (frame_ok) begin
                cmd_q  <= cmd_s;
                data_q <= {hi_s, lo_s};
            end
        end
    end

    assign cmd_if.cmd_valid_o = cmd_valid_q;
    assign cmd_if.cmd_o       = cmd_q;
    assign cmd_if.data_o      = data_q;
    assign cmd_if.chk_err_o   = chk_err_q;
    assign cmd_if.frm_err_o   = frm_err;
    assign cmd_if.busy_o      = (p_state != P_HDR);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx

module tb_uart_cmd_rx;

    localparam int CLK_DIV = 8;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd_i  (rxd),
        .cmd_if (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Observed strobe events, captured away from the active edge.
    typedef struct {
        bit          err;
        logic [7:0]  cmd;
        logic [15:0] data;
    } ev_t;

    ev_t evq[$];
    ev_t exp_q[$];
    int  frm_cnt    = 0;
    int  width_viol = 0;
    logic prev_v = 1'b0, prev_c = 1'b0, prev_f = 1'b0;

    always @(negedge clk) begin
        if (bus.cmd_valid_o === 1'b1) evq.push_back('{1'b0, bus.cmd_o, bus.data_o});
        if (bus.chk_err_o === 1'b1)   evq.push_back('{1'b1, bus.cmd_o, bus.data_o});
        if (bus.frm_err_o === 1'b1)   frm_cnt++;
        if ((bus.cmd_valid_o && prev_v) || (bus.chk_err_o && prev_c) || (bus.frm_err_o && prev_f))
            width_viol++;
        prev_v = bus.cmd_valid_o;
        prev_c = bus.chk_err_o;
        prev_f = bus.frm_err_o;
    end

    // ---------------- line driver ----------------
    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(h, 1'b1);
        send_byte(l, 1'b1);
        send_byte(k, 1'b1);
    endtask

    // ---------------- reference model ----------------
    // Scans a byte stream: every A5 seen while hunting opens a 4-byte body;
    // a complete body yields a valid or checksum-error event, an incomplete
    // trailing body is dropped (it times out on the idle line afterwards).
    logic [7:0]  stream[$];
    logic [7:0]  model_cmd;
    logic [15:0] model_data;

    task automatic run_model();
        int i;
        logic [7:0] c, h, l, k;
        i = 0;
        while (i < stream.size()) begin
            if (stream[i] == 8'hA5 && i + 4 < stream.size()) begin
                c = stream[i+1]; h = stream[i+2]; l = stream[i+3]; k = stream[i+4];
                if ((c ^ h ^ l) == k) begin
                    model_cmd  = c;
                    model_data = {h, l};
                    exp_q.push_back('{1'b0, c, {h, l}});
                end else begin
                    exp_q.push_back('{1'b1, model_cmd, model_data});
                end
                i += 5;
            end else begin
                i++;
            end
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, evq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
            check({tag, "_kind"}, 32'(evq[i].err), 32'(exp_q[i].err));
            check({tag, "_cmd"},  32'(evq[i].cmd), 32'(exp_q[i].cmd));
            check({tag, "_data"}, 32'(evq[i].data), 32'(exp_q[i].data));
        end
        exp_q.delete();
        evq.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          n;
        logic [7:0]  b[7];
        int          nv;
        int          ne;
        logic [7:0]  cmd;
        logic [15:0] data;
    } vec_t;

    vec_t tab[$];

    task automatic add_vec(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                           input int nv, input int ne, input logic [7:0] cmd, input logic [15:0] data);
        vec_t v;
        v.n = n;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5; v.b[6] = b6;
        v.nv = nv; v.ne = ne; v.cmd = cmd; v.data = data;
        tab.push_back(v);
    endtask

    task automatic count_events(output int nv, output int ne);
        nv = 0;
        ne = 0;
        foreach (evq[i]) begin
            if (evq[i].err) ne++;
            else            nv++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, ne, frm_base;
        logic [7:0] c, h, l, k;

        add_vec(5, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 8'h00, 1, 0, 8'h01, 16'h1234);
        add_vec(5, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h28, 8'h00, 8'h00, 0, 1, 8'h01, 16'h1234);
        add_vec(7, 8'hFF, 8'h00, 8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64, 1, 0, 8'h02, 16'hABCD);
        add_vec(5, 8'hA5, 8'h03, 8'h00, 8'h10, 8'h13, 8'h00, 8'h00, 1, 0, 8'h03, 16'h0010);
        add_vec(5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1, 0, 8'hA5, 16'h0000);
        add_vec(5, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, 0, 8'hFF, 16'hFFFF);
        add_vec(5, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 1, 0, 8'h10, 16'h2030);
        add_vec(6, 8'h5A, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h01, 8'h00, 0, 1, 8'h10, 16'h2030);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(bus.cmd_valid_o), 0);
        check("rst_chk_err",   32'(bus.chk_err_o), 0);
        check("rst_frm_err",   32'(bus.frm_err_o), 0);
        check("rst_busy",      32'(bus.busy_o), 0);
        check("rst_cmd",       32'(bus.cmd_o), 0);
        check("rst_data",      32'(bus.data_o), 0);
        rst = 1'b0;
        idle(10);

        // Short glitch must produce nothing.
        frm_base = frm_cnt;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(50);
        check("glitch_events", evq.size(), 0);
        check("glitch_frm",    frm_cnt - frm_base, 0);
        check("glitch_busy",   32'(bus.busy_o), 0);

        // Table-driven frames, sent back-to-back within each row.
        foreach (tab[r]) begin
            evq.delete();
            frm_base = frm_cnt;
            for (int j = 0; j < tab[r].n; j++) send_byte(tab[r].b[j], 1'b1);
            idle(4 * CLK_DIV);
            count_events(nv, ne);
            check($sformatf("vec%0d_valid", r), nv, tab[r].nv);
            check($sformatf("vec%0d_chkerr", r), ne, tab[r].ne);
            check($sformatf("vec%0d_cmd", r),  32'(bus.cmd_o), 32'(tab[r].cmd));
            check($sformatf("vec%0d_data", r), 32'(bus.data_o), 32'(tab[r].data));
            check($sformatf("vec%0d_busy", r), 32'(bus.busy_o), 0);
            check($sformatf("vec%0d_frm", r),  frm_cnt - frm_base, 0);
        end

        // Framing error mid-frame aborts it; the next frame decodes.
        evq.delete();
        frm_base = frm_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(3 * CLK_DIV);
        check("frm_pulse", frm_cnt - frm_base, 1);
        check("frm_busy",  32'(bus.busy_o), 0);
        idle(20 * CLK_DIV);
        check("frm_events", evq.size(), 0);
        send_frame(8'h03, 8'h00, 8'h10, 8'h13);
        idle(4 * CLK_DIV);
        exp_q.push_back('{1'b0, 8'h03, 16'h0010});
        compare_events("frm_next");

        // Timeout drops a partial frame; the tail is ignored.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(10);
        check("to_busy_mid", 32'(bus.busy_o), 1);
        idle(240);
        check("to_busy_after", 32'(bus.busy_o), 0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h27, 1'b1);
        idle(4 * CLK_DIV);
        check("to_tail_events", evq.size(), 0);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27);
        idle(4 * CLK_DIV);
        exp_q.push_back('{1'b0, 8'h01, 16'h1234});
        compare_events("to_next");

        // Reset in the middle of the DLO byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rxd = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_cmd_valid", 32'(bus.cmd_valid_o), 0);
        check("mrst_chk_err",   32'(bus.chk_err_o), 0);
        check("mrst_frm_err",   32'(bus.frm_err_o), 0);
        check("mrst_busy",      32'(bus.busy_o), 0);
        check("mrst_cmd",       32'(bus.cmd_o), 0);
        check("mrst_data",      32'(bus.data_o), 0);
        idle(20 * CLK_DIV);
        check("mrst_events", evq.size(), 0);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27);
        idle(4 * CLK_DIV);
        exp_q.push_back('{1'b0, 8'h01, 16'h1234});
        compare_events("mrst_next");

        // Randomized streams against the reference model.
        model_cmd  = 8'h01;
        model_data = 16'h1234;
        for (int batch = 0; batch < 6; batch++) begin
            stream.delete();
            repeat (8) begin
                case ($urandom_range(0, 3))
                    0, 1: begin
                        c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
                        k = c ^ h ^ l;
                        stream.push_back(8'hA5); stream.push_back(c); stream.push_back(h);
                        stream.push_back(l); stream.push_back(k);
                    end
                    2: begin
                        c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
                        k = c ^ h ^ l ^ 8'($urandom_range(1, 255));
                        stream.push_back(8'hA5); stream.push_back(c); stream.push_back(h);
                        stream.push_back(l); stream.push_back(k);
                    end
                    default: stream.push_back(8'($urandom));
                endcase
            end
            foreach (stream[j]) send_byte(stream[j], 1'b1);
            idle(TIMEOUT + 50);
            run_model();
            compare_events($sformatf("rand%0d", batch));
            check($sformatf("rand%0d_busy", batch), 32'(bus.busy_o), 0);
        end

        check("strobe_width", width_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
